// File: rtl/calc_seq_if.sv
// Keypad-to-display link for the calculator sequencer: key strobe in, display and status out.
interface calc_seq_if #(
  parameter int W = 40
);
  logic         i_key_valid;
  logic [3:0]   i_key_code;
  logic [W-1:0] o_value;
  logic         o_sign;
  logic         o_err;
  logic         o_busy;
  logic [2:0]   o_state;

  modport master (
    output i_key_valid, i_key_code,
    input  o_value, o_sign, o_err, o_busy, o_state
  );

  modport slave (
    input  i_key_valid, i_key_code,
    output o_value, o_sign, o_err, o_busy, o_state
  );
endinterface

// File: rtl/calc_seq_ctrl.sv
// Calculator-mode sequencer: digit entry, pending operator, one-cycle signed-magnitude add/sub,
// display overflow detection with a sticky error.
//
// state   | meaning
// ENTER_A | collecting first operand (or a fresh operand after a result)
// OP      | operator latched, acc shown, waiting for second operand
// ENTER_B | collecting second operand
// EXEC    | one-cycle add/subtract, keys dropped
// RESULT  | result shown in acc
// ERR     | display overflow, only CLR leaves
module calc_seq_ctrl #(
  parameter int DIGITS = 6,
  parameter int W      = 40
) (
  input  logic      i_clk,
  input  logic      i_rst,
  calc_seq_if.slave bus
);
  localparam int CW = $clog2(DIGITS + 1);

  localparam logic [2:0] ENTER_A = 3'd0;
  localparam logic [2:0] OP      = 3'd1;
  localparam logic [2:0] ENTER_B = 3'd2;
  localparam logic [2:0] EXEC    = 3'd3;
  localparam logic [2:0] RESULT  = 3'd4;
  localparam logic [2:0] ERR     = 3'd5;

  localparam logic [3:0] K_ADD = 4'd10;
  localparam logic [3:0] K_SUB = 4'd11;
  localparam logic [3:0] K_EQU = 4'd12;
  localparam logic [3:0] K_CLR = 4'd13;
  localparam logic [3:0] K_NEG = 4'd14;

  function automatic logic [W-1:0] pow10(input int n);
    logic [W-1:0] p;
    p = W'(1);
    for (int i = 0; i < n; i++) p = p * W'(10);
    return p;
  endfunction

  // the minus sign takes a display digit, so negatives get one digit less
  localparam logic [W-1:0] POS_LIM = pow10(DIGITS) - W'(1);
  localparam logic [W-1:0] NEG_LIM = pow10(DIGITS - 1) - W'(1);

  logic [2:0]    state, state_n;
  logic [W-1:0]  ent_mag, ent_mag_n, acc_mag, acc_mag_n;
  logic          ent_sign, ent_sign_n, acc_sign, acc_sign_n;
  logic [CW-1:0] ent_cnt, ent_cnt_n;
  logic          op, op_n, next_op, next_op_n, chain, chain_n, err, err_n;
  logic [W-1:0]  val_q, val_n;
  logic          sign_q, sign_n, busy_q;

  logic [3:0]    code;
  logic [W-1:0]  dig, ent_x10;
  logic          is_digit, is_addsub, dig_ok;
  logic          b_neg, res_sign, ovf;
  logic [W:0]    res_mag;

  assign code      = bus.i_key_code;
  assign dig       = {{(W-4){1'b0}}, code};
  assign is_digit  = (code <= 4'd9);
  assign is_addsub = (code == K_ADD) || (code == K_SUB);
  assign ent_x10   = (ent_mag << 3) + (ent_mag << 1) + dig;
  assign dig_ok    = (ent_cnt != CW'(DIGITS)) && !(ent_sign && ent_cnt == CW'(DIGITS - 1))
                     && !(ent_mag == '0 && code == 4'd0);

  always_comb begin
    b_neg    = ent_sign ^ op;
    res_mag  = '0;
    res_sign = 1'b0;
    if (acc_sign == b_neg) begin
      res_mag  = {1'b0, acc_mag} + {1'b0, ent_mag};
      res_sign = acc_sign;
    end else if (acc_mag > ent_mag) begin
      res_mag  = {1'b0, acc_mag - ent_mag};
      res_sign = acc_sign;
    end else if (ent_mag > acc_mag) begin
      res_mag  = {1'b0, ent_mag - acc_mag};
      res_sign = b_neg;
    end
    ovf = res_sign ? (res_mag > {1'b0, NEG_LIM}) : (res_mag > {1'b0, POS_LIM});
  end

  always_comb begin
    state_n    = state;
    ent_mag_n  = ent_mag;
    ent_sign_n = ent_sign;
    ent_cnt_n  = ent_cnt;
    acc_mag_n  = acc_mag;
    acc_sign_n = acc_sign;
    op_n       = op;
    next_op_n  = next_op;
    chain_n    = chain;
    err_n      = err;

    if (state == EXEC) begin
      if (ovf) begin
        state_n = ERR;
        err_n   = 1'b1;
      end else begin
        acc_mag_n  = res_mag[W-1:0];
        acc_sign_n = res_sign;
        ent_mag_n  = '0;
        ent_sign_n = 1'b0;
        ent_cnt_n  = '0;
        if (chain) begin
          op_n    = next_op;
          state_n = OP;
        end else begin
          state_n = RESULT;
        end
      end
    end else if (bus.i_key_valid) begin
      if (code == K_CLR) begin
        state_n    = ENTER_A;
        ent_mag_n  = '0;
        ent_sign_n = 1'b0;
        ent_cnt_n  = '0;
        acc_mag_n  = '0;
        acc_sign_n = 1'b0;
        op_n       = 1'b0;
        next_op_n  = 1'b0;
        chain_n    = 1'b0;
        err_n      = 1'b0;
      end else begin
        case (state)
          ENTER_A, ENTER_B: begin
            if (is_digit) begin
              if (dig_ok) begin
                ent_mag_n = ent_x10;
                ent_cnt_n = ent_cnt + CW'(1);
              end
            end else if (code == K_NEG) begin
              if (ent_sign || ent_cnt != CW'(DIGITS)) ent_sign_n = ~ent_sign;
            end else if (is_addsub) begin
              if (state == ENTER_A) begin
                acc_mag_n  = ent_mag;
                acc_sign_n = ent_sign;
                op_n       = (code == K_SUB);
                ent_mag_n  = '0;
                ent_sign_n = 1'b0;
                ent_cnt_n  = '0;
                state_n    = OP;
              end else begin
                chain_n   = 1'b1;
                next_op_n = (code == K_SUB);
                state_n   = EXEC;
              end
            end else if (code == K_EQU && state == ENTER_B) begin
              chain_n = 1'b0;
              state_n = EXEC;
            end
          end
          OP: begin
            if (is_digit) begin
              ent_mag_n  = dig;
              ent_sign_n = 1'b0;
              ent_cnt_n  = (code != 4'd0) ? CW'(1) : '0;
              state_n    = ENTER_B;
            end else if (code == K_NEG) begin
              ent_mag_n  = '0;
              ent_sign_n = 1'b1;
              ent_cnt_n  = '0;
              state_n    = ENTER_B;
            end else if (is_addsub) begin
              op_n = (code == K_SUB);
            end
          end
          RESULT: begin
            if (is_digit) begin
              acc_mag_n  = '0;
              acc_sign_n = 1'b0;
              ent_mag_n  = dig;
              ent_sign_n = 1'b0;
              ent_cnt_n  = (code != 4'd0) ? CW'(1) : '0;
              state_n    = ENTER_A;
            end else if (code == K_NEG) begin
              if (acc_mag != '0) acc_sign_n = ~acc_sign;
            end else if (is_addsub) begin
              op_n    = (code == K_SUB);
              state_n = OP;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    val_n  = acc_mag;
    sign_n = acc_sign;
    case (state_n)
      ENTER_A, ENTER_B: begin
        val_n  = ent_mag_n;
        sign_n = ent_sign_n;
      end
      OP, EXEC, RESULT: begin
        val_n  = acc_mag_n;
        sign_n = acc_sign_n;
      end
      default: begin
        val_n  = '0;
        sign_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ENTER_A;
      ent_mag  <= '0;
      ent_sign <= 1'b0;
      ent_cnt  <= '0;
      acc_mag  <= '0;
      acc_sign <= 1'b0;
      op       <= 1'b0;
      next_op  <= 1'b0;
      chain    <= 1'b0;
      err      <= 1'b0;
      val_q    <= '0;
      sign_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_n;
      ent_mag  <= ent_mag_n;
      ent_sign <= ent_sign_n;
      ent_cnt  <= ent_cnt_n;
      acc_mag  <= acc_mag_n;
      acc_sign <= acc_sign_n;
      op       <= op_n;
      next_op  <= next_op_n;
      chain    <= chain_n;
      err      <= err_n;
      val_q    <= val_n;
      sign_q   <= sign_n;
      busy_q   <= (state_n == EXEC);
    end
  end

  assign bus.o_value = val_q;
  assign bus.o_sign  = sign_q;
  assign bus.o_err   = err;
  assign bus.o_busy  = busy_q;
  assign bus.o_state = state;
endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Directed bench for calc_seq_ctrl: a signed-integer calculator model checked every cycle,
// plus literal checkpoints at the interesting points of each key sequence.
module tb_calc_seq_ctrl;
  localparam int W = 40;
  localparam int S_EA = 0, S_OP = 1, S_EB = 2, S_EX = 3, S_RS = 4, S_ER = 5;
  localparam int ADD = 10, SUB = 11, EQU = 12, CLR = 13, NEG = 14, NOP = 15;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  calc_seq_if #(.W(W)) bus();
  calc_seq_ctrl #(.DIGITS(6), .W(W)) dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus));

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  // model: operands as plain integers, entry sign kept apart so a "-0" entry is representable
  longint e_mag, a_mag;
  bit     e_neg, a_neg, m_sub, m_next_sub, m_chain, m_err, started;
  int     e_cnt, ms;

  task automatic m_clear();
    e_mag = 0; e_neg = 0; e_cnt = 0; a_mag = 0; a_neg = 0;
    m_sub = 0; m_next_sub = 0; m_chain = 0; m_err = 0; ms = S_EA;
  endtask

  task automatic m_clear_entry();
    e_mag = 0; e_neg = 0; e_cnt = 0;
  endtask

  task automatic m_exec();
    longint a, b, r;
    a = a_neg ? -a_mag : a_mag;
    b = e_neg ? -e_mag : e_mag;
    r = m_sub ? a - b : a + b;
    if (r > 999999 || r < -99999) begin
      ms = S_ER; m_err = 1;
    end else begin
      a_neg = (r < 0);
      a_mag = a_neg ? -r : r;
      m_clear_entry();
      if (m_chain) begin m_sub = m_next_sub; ms = S_OP; end
      else ms = S_RS;
    end
  endtask

  task automatic m_key(input int k);
    bit entering;
    entering = (ms == S_EA || ms == S_EB);
    if (k == CLR) begin m_clear(); return; end
    if (ms == S_ER) return;
    if (k <= 9) begin
      if (entering) begin
        if (e_cnt < 6 && !(e_neg && e_cnt == 5) && !(e_mag == 0 && k == 0)) begin
          e_mag = e_mag * 10 + k; e_cnt++;
        end
      end else if (ms == S_OP) begin
        e_mag = k; e_neg = 0; e_cnt = (k != 0); ms = S_EB;
      end else if (ms == S_RS) begin
        a_mag = 0; a_neg = 0; e_mag = k; e_neg = 0; e_cnt = (k != 0); ms = S_EA;
      end
    end else if (k == NEG) begin
      if (entering) begin
        if (e_neg || e_cnt < 6) e_neg = !e_neg;
      end else if (ms == S_OP) begin
        m_clear_entry(); e_neg = 1; ms = S_EB;
      end else if (ms == S_RS && a_mag != 0) a_neg = !a_neg;
    end else if (k == ADD || k == SUB) begin
      if (ms == S_EA) begin
        a_mag = e_mag; a_neg = e_neg; m_sub = (k == SUB); m_clear_entry(); ms = S_OP;
      end else if (ms == S_EB) begin
        m_chain = 1; m_next_sub = (k == SUB); ms = S_EX;
      end else if (ms == S_OP) m_sub = (k == SUB);
      else if (ms == S_RS) begin m_sub = (k == SUB); ms = S_OP; end
    end else if (k == EQU && ms == S_EB) begin
      m_chain = 0; ms = S_EX;
    end
  endtask

  always @(posedge i_clk) begin
    started = 1;
    if (i_rst) m_clear();
    else if (ms == S_EX) m_exec();
    else if (bus.i_key_valid) m_key(int'(bus.i_key_code));
  end

  task automatic cmp(input string nm, input logic [63:0] got, input longint exp);
    total++;
    if (got !== 64'(exp)) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge i_clk) begin
    if (started) begin
      longint ev;
      bit es;
      if (ms == S_EA || ms == S_EB) begin ev = e_mag; es = e_neg; end
      else if (ms == S_ER) begin ev = 0; es = 0; end
      else begin ev = a_mag; es = a_neg; end
      cmp("model_value", {24'd0, bus.o_value}, ev);
      cmp("model_sign",  {63'd0, bus.o_sign},  longint'(es));
      cmp("model_err",   {63'd0, bus.o_err},   longint'(m_err));
      cmp("model_busy",  {63'd0, bus.o_busy},  longint'(ms == S_EX));
      cmp("model_state", {61'd0, bus.o_state}, longint'(ms));
    end
  end

  // called at a falling edge; the key is sampled on the next rising edge
  task automatic press(input int k);
    bus.i_key_valid = 1'b1;
    bus.i_key_code  = 4'(k);
    @(negedge i_clk);
    bus.i_key_valid = 1'b0;
  endtask

  task automatic idle();
    @(negedge i_clk);
  endtask

  task automatic chk_out(input string nm, input longint v, input longint s, input longint st);
    cmp({nm, "_value"}, {24'd0, bus.o_value}, v);
    cmp({nm, "_sign"},  {63'd0, bus.o_sign},  s);
    cmp({nm, "_state"}, {61'd0, bus.o_state}, st);
  endtask

  initial begin
    bus.i_key_valid = 1'b0;
    bus.i_key_code  = 4'd0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    chk_out("reset", 0, 0, S_EA);
    cmp("reset_err",  {63'd0, bus.o_err},  0);
    cmp("reset_busy", {63'd0, bus.o_busy}, 0);

    press(1); press(2); press(EQU);
    chk_out("equ_ignored", 12, 0, S_EA);
    press(ADD); press(5); press(EQU);
    cmp("exec_busy", {63'd0, bus.o_busy}, 1);
    cmp("exec_state", {61'd0, bus.o_state}, S_EX);
    idle();
    cmp("after_exec_busy", {63'd0, bus.o_busy}, 0);
    chk_out("add_17", 17, 0, S_RS);

    press(CLR); press(3); press(SUB); press(8); press(EQU); idle();
    chk_out("sub_neg5", 5, 1, S_RS);
    press(NEG);
    chk_out("neg_result", 5, 0, S_RS);

    press(CLR);
    for (int i = 0; i < 7; i++) press(9);
    chk_out("digit_limit", 999999, 0, S_EA);
    press(NEG);
    chk_out("neg_full_ignored", 999999, 0, S_EA);
    press(ADD); press(1); press(EQU); idle();
    chk_out("pos_ovf", 0, 0, S_ER);
    cmp("pos_ovf_err", {63'd0, bus.o_err}, 1);
    press(7); press(NOP);
    chk_out("err_ignores", 0, 0, S_ER);
    press(CLR);
    chk_out("clr_from_err", 0, 0, S_EA);
    cmp("clr_err", {63'd0, bus.o_err}, 0);

    press(5); for (int i = 0; i < 4; i++) press(0);
    press(NEG); press(SUB); press(5); for (int i = 0; i < 4; i++) press(0);
    press(EQU); idle();
    chk_out("neg_ovf", 0, 0, S_ER);
    cmp("neg_ovf_err", {63'd0, bus.o_err}, 1);
    press(CLR);
    press(5); for (int i = 0; i < 4; i++) press(0);
    press(NEG); press(SUB); press(4); for (int i = 0; i < 4; i++) press(9);
    press(EQU); idle();
    chk_out("neg_limit", 99999, 1, S_RS);
    cmp("neg_limit_err", {63'd0, bus.o_err}, 0);

    press(CLR); press(2); press(ADD); press(3); press(SUB); idle();
    chk_out("chain", 5, 0, S_OP);
    press(1); press(EQU); idle();
    chk_out("chain_result", 4, 0, S_RS);

    press(CLR); press(2); press(ADD); press(3); press(SUB); press(7);
    chk_out("drop_in_exec", 5, 0, S_OP);
    press(1); press(EQU); press(CLR);
    chk_out("clr_dropped", 4, 0, S_RS);

    press(CLR);
    bus.i_key_valid = 1'b1; bus.i_key_code = 4'd4;
    repeat (3) @(negedge i_clk);
    bus.i_key_valid = 1'b0;
    chk_out("held_key", 444, 0, S_EA);

    press(CLR); press(0); press(1); press(2); press(3); press(4); press(5); press(NEG); press(6);
    chk_out("neg_digit_limit", 12345, 1, S_EA);
    press(NEG); press(6);
    chk_out("pos_sixth_digit", 123456, 0, S_EA);

    press(CLR); press(2); press(ADD); press(7);
    chk_out("in_enter_b", 7, 0, S_EB);
    i_rst = 1'b1; bus.i_key_valid = 1'b1; bus.i_key_code = 4'd3;
    @(negedge i_clk);
    i_rst = 1'b0; bus.i_key_valid = 1'b0;
    chk_out("reset_with_key", 0, 0, S_EA);
    cmp("reset_with_key_err", {63'd0, bus.o_err}, 0);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
